// File: rtl/memory_slave.sv
// memory_slave: a small word-addressed storage target with a request/response
// handshake. A request is captured in IDLE, serviced in ACCESS and answered
// with a one-cycle slv_rsp pulse in RESP, giving one request per three cycles.
// Requests outside 0..MEM_SIZE-1 are answered with err instead of touching
// storage. Storage is cleared by reset, so it is built from flops.
module memory_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 31,
  parameter int MEM_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slv_rsp,
  output logic                  err,
  output logic                  busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Word index width, and a compare width wide enough for both the full
  // address and MEM_SIZE so the range check never truncates or wraps.
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
  localparam logic [CMP_W-1:0] MEM_LIMIT = CMP_W'(MEM_SIZE);

  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic                  wr_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  rsp_reg;
  logic                  err_reg;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [MEM_SIZE-1:0]   word_we;
  logic [IDX_W-1:0]      mem_idx;
  logic                  in_range;
  logic                  accept;
  logic                  in_access;
  logic                  do_write;
  logic [DATA_WIDTH-1:0] rd_word;

  assign accept    = (state_reg == IDLE) && en;
  assign in_access = (state_reg == ACCESS);
  assign in_range  = (CMP_W'(addr_reg) < MEM_LIMIT);
  assign mem_idx   = IDX_W'(addr_reg);
  assign do_write  = in_access && wr_reg && in_range;
  // Out-of-range reads return zero rather than an aliased word.
  assign rd_word   = in_range ? mem[mem_idx] : '0;

  // Next-state logic: IDLE -> ACCESS on a request, then ACCESS -> RESP -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Request capture: only in IDLE, so inputs changing later cannot disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      wr_reg    <= wr;
      addr_reg  <= addr;
      wdata_reg <= wdata;
    end
  end

  // One write-enable per word, decoded from the captured address.
  genvar gi;
  generate
    for (gi = 0; gi < MEM_SIZE; gi++) begin : g_word_we
      assign word_we[gi] = do_write && (mem_idx == IDX_W'(gi));
    end
  endgenerate

  // Storage words: cleared by reset, written during ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        if (word_we[i]) mem[i] <= wdata_reg;
      end
    end
  end

  // Response registers: rdata only changes on a read completion; slv_rsp and
  // err are set leaving ACCESS so they are high for exactly the RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
      rsp_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      rsp_reg <= in_access;
      err_reg <= in_access && !in_range;
      if (in_access && !wr_reg) rdata_reg <= rd_word;
    end
  end

  assign rdata   = rdata_reg;
  assign slv_rsp = rsp_reg;
  assign err     = err_reg;
  assign busy    = (state_reg != IDLE);

endmodule
